// File: rtl/rv_busarb.sv
// rv_busarb: two-master, single-slave arbiter for the rv_core data bus.
// Round-robin with direct hand-off between masters. The watchdog aborts any
// granted transfer that the slave leaves waiting for TIMEOUT cycles.
//
// Ports:
//   clk, reset              bus clock, synchronous active-high reset
//   m0_* / m1_*             master ports (adr/re/we/dw in, dr/rdy out)
//   s_*                     shared slave port (adr/re/we/dw out, dr/rdy in)
//   gnt                     one-hot current grant (bit0 = m0, bit1 = m1)
//   tmo_err                 one-cycle pulse in the watchdog abort cycle
//   tmo_src                 master id of the most recent abort
module rv_busarb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_adr,
  input  logic        m0_re,
  input  logic [3:0]  m0_we,
  input  logic [31:0] m0_dw,
  output logic [31:0] m0_dr,
  output logic        m0_rdy,
  input  logic [31:0] m1_adr,
  input  logic        m1_re,
  input  logic [3:0]  m1_we,
  input  logic [31:0] m1_dw,
  output logic [31:0] m1_dr,
  output logic        m1_rdy,
  output logic [31:0] s_adr,
  output logic        s_re,
  output logic [3:0]  s_we,
  output logic [31:0] s_dw,
  input  logic [31:0] s_dr,
  input  logic        s_rdy,
  output logic [1:0]  gnt,
  output logic        tmo_err,
  output logic        tmo_src
);

  // Encodings double as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TMO_LAST = TMO_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic [15:0] r_cnt;
  logic        r_tmo_src;

  logic w_req0, w_req1;
  logic w_g0, w_g1;
  logic w_abort;
  logic w_done;

  assign w_req0 = m0_re | (|m0_we);
  assign w_req1 = m1_re | (|m1_we);
  assign w_g0   = (r_state == GNT0);
  assign w_g1   = (r_state == GNT1);

  // Abort cycle: the last allowed wait cycle passes without s_rdy.
  assign w_abort = TMO_EN && (w_g0 || w_g1) && !s_rdy && (r_cnt == TMO_LAST);
  assign w_done  = (w_g0 || w_g1) && (s_rdy || w_abort);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) w_next = r_last ? GNT0 : GNT1;
        else if (w_req0)      w_next = GNT0;
        else if (w_req1)      w_next = GNT1;
      end
      // A completing master is not re-granted on the same edge.
      GNT0: begin
        if (w_done)       w_next = w_req1 ? GNT1 : IDLE;
        else if (!w_req0) w_next = IDLE;
      end
      GNT1: begin
        if (w_done)       w_next = w_req0 ? GNT0 : IDLE;
        else if (!w_req1) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_tmo_src <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_done) r_last <= w_g1;
      // Any grant entry or completion leaves the counter at zero.
      if (r_state != IDLE && !w_done && w_next == r_state)
        r_cnt <= r_cnt + 16'd1;
      else
        r_cnt <= '0;
      if (w_abort) r_tmo_src <= w_g1;
    end
  end

  always_comb begin
    s_adr = '0;
    s_re  = 1'b0;
    s_we  = '0;
    s_dw  = '0;
    if (w_g0) begin
      s_adr = m0_adr;
      s_re  = m0_re;
      s_we  = m0_we;
      s_dw  = m0_dw;
    end else if (w_g1) begin
      s_adr = m1_adr;
      s_re  = m1_re;
      s_we  = m1_we;
      s_dw  = m1_dw;
    end
    if (w_abort) begin
      s_re = 1'b0;
      s_we = '0;
    end
  end

  assign m0_rdy  = w_g0 & (s_rdy | w_abort);
  assign m1_rdy  = w_g1 & (s_rdy | w_abort);
  assign m0_dr   = (w_g0 && s_rdy) ? s_dr : '0;
  assign m1_dr   = (w_g1 && s_rdy) ? s_dr : '0;
  assign gnt     = r_state;
  assign tmo_err = w_abort;
  assign tmo_src = r_tmo_src;

endmodule

// File: doc/rv_busarb.md
# rv_busarb

Two-master, single-slave arbiter for the rv_core data-bus protocol (adr/re/we/dw/dr/rdy). It shares one slave port, such as the mem_if cache port or a peripheral segment, between the CPU data port (master 0) and a second bus master such as a DMA engine (master 1). Arbitration is round-robin with direct hand-off. A watchdog aborts transfers the slave never completes.

## Interface
Parameters:
- TIMEOUT, default 255: maximum cycles a granted transfer may wait for s_rdy; 0 disables the watchdog. Range 0..65535.

Ports:
- clk  in  1  bus clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- m0_adr  in  32  master 0 address
- m0_re  in  1  master 0 read enable
- m0_we  in  4  master 0 byte write enables
- m0_dw  in  32  master 0 write data
- m0_dr  out  32  master 0 read data; zero when not completing
- m0_rdy  out  1  master 0 transfer complete (1-cycle)
- m1_adr, m1_re, m1_we, m1_dw, m1_dr, m1_rdy: same widths and meaning for master 1
- s_adr  out  32  slave address
- s_re  out  1  slave read enable
- s_we  out  4  slave byte write enables
- s_dw  out  32  slave write data
- s_dr  in  32  slave read data
- s_rdy  in  1  slave transfer complete
- gnt  out  2  one-hot current grant; bit0 = m0, bit1 = m1; 0 = idle
- tmo_err  out  1  one-cycle pulse on watchdog abort
- tmo_src  out  1  master id of the most recent abort; holds until the next abort

## Operation
- Request: mX_req = mX_re | (|mX_we). A master holds adr/re/we/dw stable until it sees mX_rdy.
- State machine (registered): IDLE, GNT0, GNT1. gnt mirrors state.
- IDLE:
  - only one master requesting -> grant that master.
  - both requesting -> grant the master that is not `last`.
  - `last` is a 1-bit register, reset to 1, so m0 wins first after reset.
- GNTx, s_rdy=1 (completion): `last` <= x.
  - The other master requesting -> go directly to GNT(other).
  - Else -> IDLE.
  - The completing master's request in this cycle is treated as finished; it is not re-granted on this edge.
- GNTx, s_rdy=0: stay in GNTx. If mX_req drops (illegal), go to IDLE and do not update `last`.
- Slave mux (combinational from state):
  - GNTx: s_adr/s_re/s_we/s_dw = master x signals.
  - IDLE: all zero.
- Return path:
  - mX_rdy = (state==GNTx) & s_rdy.
  - mX_dr = s_dr when mX_rdy, else 0, so outputs can be OR-combined on a shared read bus.
- Watchdog (TIMEOUT>0):
  - 16-bit counter; cleared on entry to any GNT state and on completion; increments each GNT cycle with s_rdy=0.
  - When the counter equals TIMEOUT-1 and s_rdy=0, that cycle is the abort cycle:
    - mX_rdy=1, mX_dr=0.
    - tmo_err=1; tmo_src <= x.
    - s_re/s_we forced to 0 in the abort cycle.
    - `last` <= x; next state follows the completion rules.
- s_rdy while IDLE is ignored.

## Timing
- Reset values: state IDLE, gnt=0, `last`=1, counter 0, tmo_err=0, tmo_src=0. With state IDLE, all m*_rdy, m*_dr and s_* outputs are 0.
- Arbitration latency: request first seen high at edge N -> gnt and slave strobes valid in the cycle after edge N. Minimum transfer is 2 cycles (grant cycle, then slave responds).
- Zero-wait slave (s_rdy combinationally high when strobed): completes in the first GNT cycle.
- Hand-off between masters has no bubble. The same master issuing back-to-back transfers alone sees one IDLE cycle between them.
- Abort: with s_rdy never asserted, mX_rdy rises exactly TIMEOUT cycles after grant, with gnt counted as cycle 1.
- Reset asserted mid-transfer: state returns to IDLE on that edge. The slave strobes drop the following cycle; no rdy is issued.

## Test plan
- Single master: m0 reads 0x00000100 with slave s_rdy 3 cycles after strobe, s_dr=0x12345678 -> m0_rdy pulses once, m0_dr=0x12345678, m1_rdy=0, gnt 01 then 00.
- Simultaneous: both request from reset; slave always ready -> grant order m0, m1, m0, m1 with no idle cycles between grants; m1_dr=0 whenever m0 completes.
- Write routing: m1 writes we=4'b0011, dw=0xCAFEBABE to 0xffff0180 while m0 idle -> s_we=0011, s_dw=0xCAFEBABE, s_adr=0xffff0180 for exactly the granted cycles.
- Timeout: TIMEOUT=8, slave never ready, m1 reads -> m1_rdy and tmo_err high in the 8th granted cycle, m1_dr=0, tmo_src=1, then IDLE; with TIMEOUT=0 the same stimulus stalls indefinitely and tmo_err stays 0.
- Reset mid-transfer: assert reset during GNT0 wait -> gnt=00 and s_re=0 next cycle, no m0_rdy; after release, simultaneous requests grant m0 first.
- Stray s_rdy while IDLE -> no rdy to either master and no state change.
